calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Sequencing controller for the two-digit decimal calculator datapath.
- Accepts two BCD operands (tens/ones digits) and an opcode on a start pulse.
- Joins the digits to binary and executes add, sub, mul or div (div is iterative, one bit per cycle).
- Converts the result to four BCD digits plus a sign flag with a sequential binary-to-BCD unit, then pulses done.
- Sits between the key-entry/display logic and the arithmetic, and replaces the free-running combinational chain with a start/busy/done handshake.

Parameters:
OP_W, 8, binary operand width (max operand 99)
RES_W, 16, binary result width fed to BCD conversion (max 9801)
BCD_ITER, 16, double-dabble iterations, equal to RES_W

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  request; sampled only while busy=0
op  in  2  00 add, 01 sub, 10 mul, 11 div
a_ten  in  4  operand A tens digit
a_one  in  4  operand A ones digit
b_ten  in  4  operand B tens digit
b_one  in  4  operand B ones digit
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle completion pulse
err  out  1  invalid digit (>9) or divide by zero; held with the result
neg  out  1  result negative (sub only)
thd, hud, ten, one  out  4 each  result magnitude BCD digits

Behaviour:
- Reset: state IDLE; busy, done, err, neg = 0; all digit outputs = 0. Reset mid-operation aborts with no done pulse and gives the same values.
- Operand and op capture: latched on the edge that accepts start. Later input changes are ignored until the next start. start while busy=1 is ignored, not queued.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle): A = a_ten*10 + a_one; B likewise. Any digit >9 -> DONE with err=1 and zero result. Otherwise -> EXEC.
  - EXEC:
    - add/sub/mul: 1 cycle.
    - sub: A>=B gives A-B, neg=0. A<B gives B-A, neg=1.
    - mul: full 16-bit product.
    - div: B=0 -> DONE with err=1, zero result, checked in the first EXEC cycle. Otherwise restoring division, OP_W cycles. Quotient goes to result; remainder is kept internally.
    - -> CONV.
  - CONV: double-dabble, BCD_ITER cycles, one shift per cycle -> DONE.
  - DONE (1 cycle): done=1, busy=0, outputs updated. -> IDLE.
- Timing, for start accepted at edge k, done high during cycle:
  - add/sub/mul: k+19
  - div: k+26
  - invalid digit: k+2
  - divide by zero: k+3
- busy is high from cycle k+1 through the cycle before done.
- Output holding: outputs change only on entry to DONE and hold until the next DONE or reset. start in the DONE cycle is ignored; the next accept is possible in IDLE.
- Widths: all arithmetic is unsigned on RES_W bits. Operands are zero-extended. The result is always <10000, so there is no BCD overflow.

Optional Feature:
- Macro: CALC_REM_OUT_EN.
- Defined:
  - Adds ports rem_ten and rem_one (out, 4 each): division remainder as BCD.
  - The remainder is converted by 8 extra double-dabble cycles after CONV, so div done moves to k+34.
  - rem_* are zero for non-div ops and on err; same reset and hold rules as the result digits.
- Undefined: no rem ports, remainder discarded, timing as above.

Decomposition:
- Package calc_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - state encoding
  - OP_W, RES_W, DIGIT_MAX=9
- Natural sub-module: bin2bcd_seq, a sequential double-dabble.
  - Parameterised input width, start/done handshake.
  - Instantiated once for the result; reused for the remainder under CALC_REM_OUT_EN.
- The division iteration stays inline in the controller.

Test Plan:
1. Add: A=1,2; B=2,3; op=00 -> done at k+19; digits 0,0,3,5; neg=0; err=0; busy high k+1..k+18.
2. Sub: A=12, B=23, op=01 -> 0,0,1,1 with neg=1. Then A=50, B=50 -> 0,0,0,0 with neg=0.
3. Mul: 99*99 -> 9,8,0,1. Then 0*3 -> 0,0,0,0.
4. Div: 99/10 -> 0,0,0,9, done at k+26. With CALC_REM_OUT_EN: rem 0,9 and done at k+34.
5. Errors: B=00 with div -> err=1, digits zero, done at k+3. a_one=4'd10 -> err=1, done at k+2.
6. Handshake and reset: start re-pulsed during busy -> ignored, single done. rst asserted in the middle of CONV -> next cycle IDLE, all outputs zero, no done. New start afterwards completes normally.

Source files
------------

// File: rtl/calc_seq_ctrl_pkg.sv
// calc_seq_ctrl shared definitions: widths, opcodes, FSM states.
// Optional remainder output is enabled by CALC_REM_OUT_EN.
package calc_pkg;

    localparam int OP_W      = 8;
    localparam int RES_W     = 16;
    localparam int BCD_ITER  = RES_W;
    localparam int DIGIT_MAX = 9;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_CONV,
        S_REMC,
        S_DONE
    } state_e;

    // tens*10 + ones, computed as t*8 + t*2 + o
    function automatic logic [OP_W-1:0] join_bcd(
        input logic [3:0] t,
        input logic [3:0] o
    );
        return OP_W'({t, 3'b000}) + OP_W'({t, 1'b0}) + OP_W'(o);
    endfunction

    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Request/result bundle between key entry and the calculator controller.
// rem_ten/rem_one exist only when CALC_REM_OUT_EN is defined.
interface calc_seq_ctrl_if;

    logic       start;
    logic [1:0] op;
    logic [3:0] a_ten;
    logic [3:0] a_one;
    logic [3:0] b_ten;
    logic [3:0] b_one;
    logic       busy;
    logic       done;
    logic       err;
    logic       neg;
    logic [3:0] thd;
    logic [3:0] hud;
    logic [3:0] ten;
    logic [3:0] one;
`ifdef CALC_REM_OUT_EN
    logic [3:0] rem_ten;
    logic [3:0] rem_one;

    modport master (
        output start, op, a_ten, a_one, b_ten, b_one,
        input  busy, done, err, neg, thd, hud, ten, one,
        input  rem_ten, rem_one
    );

    modport slave (
        input  start, op, a_ten, a_one, b_ten, b_one,
        output busy, done, err, neg, thd, hud, ten, one,
        output rem_ten, rem_one
    );
`else
    modport master (
        output start, op, a_ten, a_one, b_ten, b_one,
        input  busy, done, err, neg, thd, hud, ten, one
    );

    modport slave (
        input  start, op, a_ten, a_one, b_ten, b_one,
        output busy, done, err, neg, thd, hud, ten, one
    );
`endif

endinterface

// File: rtl/calc_seq_ctrl_bin2bcd.sv
// Sequential double-dabble: W shifts after start, one per cycle.
// done_o marks the cycle of the last shift; bcd_o is then the final value.
module bin2bcd_seq #(
    parameter int W  = 16,
    parameter int ND = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [W-1:0]  bin_i,
    output logic          done_o,
    output logic [4*ND-1:0] bcd_o
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * ND;

    logic [W-1:0]  bin_q;
    logic [BW-1:0] bcd_q;
    logic [BW-1:0] adj;
    logic [BW-1:0] nxt;
    logic [CW-1:0] cnt_q;

    // add-3 correction on every digit >= 5, then shift in the next bit
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        nxt = BW'({adj, bin_q[W-1]});
    end

    // load on start, then shift until the counter drains
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= CW'(W);
        end else if (cnt_q != '0) begin
            bin_q <= {bin_q[W-2:0], 1'b0};
            bcd_q <= nxt;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign bcd_o  = nxt;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Start/busy/done sequencer for the two-digit BCD calculator.
// Define CALC_REM_OUT_EN to also report the division remainder.
module calc_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    calc_seq_ctrl_if.slave bus
);

    import calc_pkg::*;

    localparam int CNT_W = $clog2(OP_W);

    state_e             state_q;
    op_e                op_q;
    logic [15:0]        dig_q;
    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [OP_W-1:0]    quo_q;
    logic [OP_W-1:0]    rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_p_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               neg_q;
    logic [RES_W-1:0]   out_q;

    logic [OP_W-1:0]    a_bin;
    logic [OP_W-1:0]    b_bin;
    logic               dig_err;
    logic [OP_W:0]      trial;
    logic               take;
    logic [OP_W-1:0]    quo_nx;
    logic [OP_W-1:0]    rem_nx;
    logic               last_div;
    logic               div_zero;
    logic [RES_W-1:0]   res_d;
    logic               neg_d;
    logic               conv_go;
    logic               res_done;
    logic [RES_W-1:0]   res_bcd;

    assign a_bin   = join_bcd(dig_q[15:12], dig_q[11:8]);
    assign b_bin   = join_bcd(dig_q[7:4], dig_q[3:0]);
    assign dig_err = digit_bad(dig_q[15:12]) | digit_bad(dig_q[11:8])
                   | digit_bad(dig_q[7:4])   | digit_bad(dig_q[3:0]);

    // one restoring-division step: shift in next dividend bit, try subtract
    assign trial    = {rem_q, quo_q[OP_W-1]};
    assign take     = (trial >= {1'b0, b_q});
    assign rem_nx   = take ? OP_W'(trial - {1'b0, b_q}) : trial[OP_W-1:0];
    assign quo_nx   = {quo_q[OP_W-2:0], take};
    assign last_div = (cnt_q == CNT_W'(OP_W - 1));
    assign div_zero = (op_q == OP_DIV) && (b_q == '0);

    // binary result handed to the converter when EXEC finishes
    always_comb begin
        res_d = '0;
        neg_d = 1'b0;
        unique case (op_q)
            OP_ADD: res_d = RES_W'(a_q) + RES_W'(b_q);
            OP_SUB: begin
                if (a_q >= b_q) begin
                    res_d = RES_W'(a_q - b_q);
                end else begin
                    res_d = RES_W'(b_q - a_q);
                    neg_d = 1'b1;
                end
            end
            OP_MUL: res_d = RES_W'(a_q) * RES_W'(b_q);
            OP_DIV: res_d = RES_W'(quo_nx);
        endcase
    end

    assign conv_go = (state_q == S_EXEC) && !div_zero
                   && ((op_q != OP_DIV) || last_div);

    bin2bcd_seq #(
        .W  (BCD_ITER),
        .ND (4)
    ) u_res_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_go),
        .bin_i   (res_d),
        .done_o  (res_done),
        .bcd_o   (res_bcd)
    );

`ifdef CALC_REM_OUT_EN
    logic [RES_W-1:0] res_p_q;
    logic [7:0]       rem_out_q;
    logic             rem_go;
    logic             rem_done;
    logic [7:0]       rem_bcd;

    assign rem_go = (state_q == S_CONV) && res_done && (op_q == OP_DIV);

    bin2bcd_seq #(
        .W  (OP_W),
        .ND (2)
    ) u_rem_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (rem_go),
        .bin_i   (rem_q),
        .done_o  (rem_done),
        .bcd_o   (rem_bcd)
    );

    assign bus.rem_ten = rem_out_q[7:4];
    assign bus.rem_one = rem_out_q[3:0];
`endif

    // sequencer; visible outputs only change on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            dig_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_p_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            neg_q   <= 1'b0;
            out_q   <= '0;
`ifdef CALC_REM_OUT_EN
            res_p_q   <= '0;
            rem_out_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        dig_q   <= {bus.a_ten, bus.a_one, bus.b_ten, bus.b_one};
                        op_q    <= op_e'(bus.op);
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    a_q   <= a_bin;
                    b_q   <= b_bin;
                    quo_q <= a_bin;
                    rem_q <= '0;
                    cnt_q <= '0;
                    if (dig_err) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        neg_q   <= 1'b0;
                        out_q   <= '0;
`ifdef CALC_REM_OUT_EN
                        rem_out_q <= '0;
`endif
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    neg_p_q <= neg_d;
                    if (div_zero) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        neg_q   <= 1'b0;
                        out_q   <= '0;
`ifdef CALC_REM_OUT_EN
                        rem_out_q <= '0;
`endif
                    end else if (op_q == OP_DIV) begin
                        quo_q <= quo_nx;
                        rem_q <= rem_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_div) begin
                            state_q <= S_CONV;
                        end
                    end else begin
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (res_done) begin
`ifdef CALC_REM_OUT_EN
                        if (op_q == OP_DIV) begin
                            res_p_q <= res_bcd;
                            state_q <= S_REMC;
                        end else begin
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            err_q     <= 1'b0;
                            neg_q     <= neg_p_q;
                            out_q     <= res_bcd;
                            rem_out_q <= '0;
                        end
`else
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        neg_q   <= neg_p_q;
                        out_q   <= res_bcd;
`endif
                    end
                end
`ifdef CALC_REM_OUT_EN
                S_REMC: begin
                    if (rem_done) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        neg_q     <= 1'b0;
                        out_q     <= res_p_q;
                        rem_out_q <= rem_bcd;
                    end
                end
`endif
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.neg  = neg_q;
    assign bus.thd  = out_q[15:12];
    assign bus.hud  = out_q[11:8];
    assign bus.ten  = out_q[7:4];
    assign bus.one  = out_q[3:0];

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl (optionally with CALC_REM_OUT_EN).
// Expected results come from an integer model of the calculator.
module tb_calc_seq_ctrl;

    typedef struct {
        logic [15:0] res;
        logic        err;
        logic        neg;
        logic [7:0]  rem;
        int          cyc;
    } exp_t;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] at;
        logic [3:0] ao;
        logic [3:0] bt;
        logic [3:0] bo;
    } stim_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    calc_seq_ctrl_if bus();

    calc_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd4(input int r);
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        int a, b, r, m;
        e.res = '0; e.err = 1'b0; e.neg = 1'b0; e.rem = '0; e.cyc = 19;
        r = 0; m = 0;
        if (s.at > 9 || s.ao > 9 || s.bt > 9 || s.bo > 9) begin
            e.err = 1'b1; e.cyc = 2;
            return e;
        end
        a = int'(s.at) * 10 + int'(s.ao);
        b = int'(s.bt) * 10 + int'(s.bo);
        case (s.op)
            2'd0: r = a + b;
            2'd1: begin
                if (a >= b) r = a - b;
                else begin r = b - a; e.neg = 1'b1; end
            end
            2'd2: r = a * b;
            default: begin
                if (b == 0) begin
                    e.err = 1'b1; e.cyc = 3;
                    return e;
                end
                r = a / b;
                m = a % b;
                e.rem = {4'(m / 10), 4'(m % 10)};
`ifdef CALC_REM_OUT_EN
                e.cyc = 34;
`else
                e.cyc = 26;
`endif
            end
        endcase
        e.res = to_bcd4(r);
        return e;
    endfunction

    function automatic logic [15:0] obs_res();
        return {bus.thd, bus.hud, bus.ten, bus.one};
    endfunction

    function automatic logic [7:0] obs_rem();
`ifdef CALC_REM_OUT_EN
        return {bus.rem_ten, bus.rem_one};
`else
        return 8'h00;
`endif
    endfunction

    task automatic pulse_start(input stim_t s);
        @(negedge clk);
        bus.op    = s.op;
        bus.a_ten = s.at;
        bus.a_one = s.ao;
        bus.b_ten = s.bt;
        bus.b_one = s.bo;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a_ten = 4'($urandom);
        bus.a_one = 4'($urandom);
        bus.b_ten = 4'($urandom);
        bus.b_one = 4'($urandom);
    endtask

    // push expectation, start, and wait (bounded) for done
    task automatic issue(input stim_t s, output int n, output int busy_bad);
        sb.push_back(model(s));
        pulse_start(s);
        n = 0;
        busy_bad = bus.busy ? 0 : 1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
            if (!bus.busy) busy_bad++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        total++;
        if (bus.err !== 1'b0 || bus.neg !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags err=%b neg=%b want 0 0", bus.err, bus.neg);
        end
        total++;
        if (obs_res() !== 16'h0000 || obs_rem() !== 8'h00) begin
            bad++;
            $display("FAIL reset_digits got=%h/%h want 0000/00", obs_res(), obs_rem());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag, input stim_t t[], input int cnt);
        int n, bb;
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            issue(t[i], n, bb);
            e = sb.pop_front();
            total++;
            if (n + 1 != e.cyc) begin
                bad++;
                $display("FAIL %s[%0d] latency got=k+%0d want=k+%0d", tag, i, n + 1, e.cyc);
            end
            total++;
            if (obs_res() !== e.res) begin
                bad++;
                $display("FAIL %s[%0d] digits got=%h want=%h", tag, i, obs_res(), e.res);
            end
            total++;
            if (bus.err !== e.err || bus.neg !== e.neg) begin
                bad++;
                $display("FAIL %s[%0d] err/neg got=%b%b want=%b%b",
                         tag, i, bus.err, bus.neg, e.err, e.neg);
            end
            total++;
            if (bb != 0) begin
                bad++;
                $display("FAIL %s[%0d] busy_gaps got=%0d want=0", tag, i, bb);
            end
`ifdef CALC_REM_OUT_EN
            total++;
            if (obs_rem() !== e.rem) begin
                bad++;
                $display("FAIL %s[%0d] rem got=%h want=%h", tag, i, obs_rem(), e.rem);
            end
`endif
            @(posedge clk);
            #1;
            total++;
            if (bus.done !== 1'b0 || obs_res() !== e.res) begin
                bad++;
                $display("FAIL %s[%0d] hold done=%b got=%h want=0,%h",
                         tag, i, bus.done, obs_res(), e.res);
            end
        end
    endtask

    task automatic test_arith();
        stim_t t[];
        t = new[6];
        t[0] = '{2'd0, 4'd1, 4'd2, 4'd2, 4'd3};
        t[1] = '{2'd1, 4'd1, 4'd2, 4'd2, 4'd3};
        t[2] = '{2'd1, 4'd5, 4'd0, 4'd5, 4'd0};
        t[3] = '{2'd2, 4'd9, 4'd9, 4'd9, 4'd9};
        t[4] = '{2'd2, 4'd0, 4'd0, 4'd0, 4'd3};
        t[5] = '{2'd0, 4'd9, 4'd9, 4'd9, 4'd9};
        run_table("arith", t, 6);
    endtask

    task automatic test_div();
        stim_t t[];
        t = new[3];
        t[0] = '{2'd3, 4'd9, 4'd9, 4'd1, 4'd0};
        t[1] = '{2'd3, 4'd0, 4'd7, 4'd0, 4'd3};
        t[2] = '{2'd3, 4'd0, 4'd5, 4'd9, 4'd9};
        run_table("div", t, 3);
    endtask

    task automatic test_err();
        stim_t t[];
        t = new[3];
        t[0] = '{2'd3, 4'd1, 4'd2, 4'd0, 4'd0};
        t[1] = '{2'd0, 4'd1, 4'd10, 4'd2, 4'd3};
        t[2] = '{2'd2, 4'd3, 4'd3, 4'd15, 4'd1};
        run_table("err", t, 3);
    endtask

    task automatic test_random();
        stim_t t[];
        t = new[8];
        foreach (t[i]) begin
            t[i].op = 2'($urandom_range(0, 3));
            t[i].at = 4'($urandom_range(0, 9));
            t[i].ao = 4'($urandom_range(0, 9));
            t[i].bt = 4'($urandom_range(0, 9));
            t[i].bo = 4'($urandom_range(0, 9));
        end
        run_table("rand", t, 8);
    endtask

    task automatic test_back_to_back();
        stim_t s, s2;
        exp_t e;
        int ndone;
        logic [15:0] got;
        s  = '{2'd0, 4'd1, 4'd2, 4'd2, 4'd3};
        s2 = '{2'd2, 4'd9, 4'd9, 4'd9, 4'd9};
        sb.push_back(model(s));
        pulse_start(s);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.op = s2.op; bus.a_ten = s2.at; bus.a_one = s2.ao;
        bus.b_ten = s2.bt; bus.b_one = s2.bo;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        got = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                got = obs_res();
            end
        end
        e = sb.pop_front();
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL b2b_done_count got=%0d want=1", ndone);
        end
        total++;
        if (got !== e.res || obs_res() !== e.res) begin
            bad++;
            $display("FAIL b2b_result got=%h held=%h want=%h", got, obs_res(), e.res);
        end
    endtask

    task automatic test_reset_mid();
        stim_t s;
        int ndone;
        s = '{2'd2, 4'd9, 4'd9, 4'd9, 4'd9};
        pulse_start(s);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0
            || bus.neg !== 1'b0) begin
            bad++;
            $display("FAIL midrst_flags busy=%b done=%b err=%b neg=%b want 0000",
                     bus.busy, bus.done, bus.err, bus.neg);
        end
        total++;
        if (obs_res() !== 16'h0000 || obs_rem() !== 8'h00) begin
            bad++;
            $display("FAIL midrst_digits got=%h/%h want 0000/00", obs_res(), obs_rem());
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL midrst_no_done got=%0d want=0", ndone);
        end
    endtask

    task automatic test_after_reset();
        stim_t t[];
        t = new[2];
        t[0] = '{2'd0, 4'd0, 4'd4, 4'd0, 4'd5};
        t[1] = '{2'd3, 4'd9, 4'd9, 4'd1, 4'd0};
        run_table("post_rst", t, 2);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a_ten = 4'd0;
        bus.a_one = 4'd0;
        bus.b_ten = 4'd0;
        bus.b_one = 4'd0;
        test_reset();
        test_arith();
        test_div();
        test_err();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
